pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter STAGES, default 3, gives the pipeline depth: stage 0 is decode-read, stage 1 is execute, stages 2..STAGES-1 are memory/writeback (legal 3..8).
REQ-002 Parameter LOAD_STAGE, default STAGES-1, gives the first stage at which load data is forwardable (legal 2..STAGES-1).
REQ-003 clk  in  1  sole clock; one clock domain; reset is synchronous and active-high.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 dec_valid, dec_reg_we, dec_is_load  in  1 each  describe the instruction in stage 0.
REQ-006 dec_rd  in  5  destination index of the stage 0 instruction.
REQ-007 ex_rs1, ex_rs2  in  5 each  source indices of the stage 1 instruction.
REQ-008 ex_rs1_used, ex_rs2_used  in  1 each  source-read qualifiers for the stage 1 instruction.
REQ-009 redirect  in  1  taken jump or branch resolved in stage 1.
REQ-010 ext_stall  in  1  memory system stall.
REQ-011 mem_pause  in  1  last stage is starting a multi-cycle read.
REQ-012 stage_en  out  STAGES  per-stage pipeline register load enable.
REQ-013 stage_valid  out  STAGES  per-stage valid (not a bubble).
REQ-014 fwd_a, fwd_b  out  clog2(STAGES)  operand source: 0 = register file, s = stage s result.
REQ-015 ex_fire  out  1  the stage 1 instruction advances this cycle.
REQ-016 pc_en, fetch_flush  out  1 each  PC advance enable; discard the instruction being fetched.

Function
REQ-017 Per stage s>=1, hold the scoreboard entry {valid, rd, reg_we, is_load}; stage 0 mirrors the dec_* inputs.
REQ-018 A source operand matches stage s (s>=2) when all hold: the stage is valid, reg_we=1, rd==rs, rd!=0, and the matching used bit=1.
REQ-019 fwd_a and fwd_b select the lowest-numbered matching stage s, i.e. the youngest producer; with no match the output is 0.
REQ-020 The selected match is an interlock when that stage has is_load=1 and s<LOAD_STAGE.
REQ-021 freeze = ext_stall | mem_pause; while frozen, stage_en=0, pc_en=0, ex_fire=0 and no scoreboard entry changes.
REQ-022 On interlock (not frozen):
 - stage_en[0]=stage_en[1]=0 and pc_en=0.
 - Stage 2 receives a bubble (valid=0).
 - Stages >=3 advance.
 - ex_fire=0.
REQ-023 Otherwise every stage_en=1, pc_en=1, and ex_fire=stage_valid[1].
REQ-024 redirect is honoured only when ex_fire=1. On redirect:
 - fetch_flush=1.
 - Stage 1 loads a bubble instead of the stage 0 instruction.
 - The stage 0 entry is marked invalid on the same edge.
REQ-025 Priority is reset > freeze > interlock > redirect > normal flow.
REQ-026 Combinational outputs (fwd_*, ex_fire, pc_en, fetch_flush, stage_en) depend only on current state and inputs; there are no combinational loops.
REQ-027 The register file is write-through; the last stage does not need to be forwarded to stage 0.

Reset
REQ-028 While reset=1, all entries are invalid and stage_valid=0.
REQ-029 While reset=1: stage_en=all ones, pc_en=1, fetch_flush=1, fwd_a=fwd_b=0, ex_fire=0.
REQ-030 Reset asserted mid-freeze or mid-interlock discards all in-flight entries on the next edge.

Configuration
REQ-031 With PIPE_CTRL_PERF_EN defined, three 32-bit wrapping counters are present; each clears on reset:
 - perf_freeze: counts frozen cycles.
 - perf_interlock: counts interlock bubbles.
 - perf_flush: counts honoured redirects.
REQ-032 The counters are exported as outputs perf_freeze, perf_interlock and perf_flush (32 bits each).
REQ-033 Without PIPE_CTRL_PERF_EN, those ports and their logic are absent; all other behaviour is identical.

Structure
REQ-034 Package pipe_pkg holds:
 - The scoreboard entry typedef (valid, rd[4:0], reg_we, is_load).
 - Constants FWD_RF=0 and MAX_STAGES=8.
REQ-035 One sub-module, fwd_match, performs the per-operand priority match and interlock detection; it is instantiated twice (rs1, rs2).

Verification
REQ-036 STAGES=3, LOAD_STAGE=2, add x5 in stage 2, stage 1 reads rs1=5 -> fwd_a=2, fwd_b=0, ex_fire=1.
REQ-037 STAGES=4, LOAD_STAGE=3, load x7 in stage 2, stage 1 reads rs2=7:
 - Cycle 1: stage_en=4'b1100, stage_valid[2]=0 next cycle.
 - Cycle 2: fwd_b=3 and ex_fire=1.
REQ-038 Writer x0 in stage 2 while rs1=0 -> fwd_a=0 and no interlock.
REQ-039 redirect=1 with ex_fire=1:
 - fetch_flush=1 that cycle.
 - Next cycle stage_valid[1]=0.
 - perf_flush increments by 1 when PIPE_CTRL_PERF_EN is defined.
REQ-040 ext_stall held 5 cycles during an interlock, with redirect=1 throughout:
 - stage_en=0 and state is unchanged for those 5 cycles; redirect is ignored.
 - After release, the interlock bubble is inserted exactly once.
 - perf_freeze=5.
REQ-041 reset pulsed while stage_valid=3'b111 -> the following cycle stage_valid=0, fwd_a=fwd_b=0, ex_fire=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Scoreboard entries travel alongside the instruction in each stage.
package pipe_pkg;

    localparam int FWD_RF     = 0;
    localparam int MAX_STAGES = 8;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_we;
        logic       is_load;
    } sb_entry_t;

    localparam int SB_W = $bits(sb_entry_t);

    function automatic logic src_hit(
        input sb_entry_t  e,
        input logic [4:0] rs,
        input logic       used
    );
        return e.valid & e.reg_we & used
            & (e.rd == rs) & (e.rd != 5'd0);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Per-operand producer search over stages 2..STAGES-1.
// Youngest producer wins; flags loads whose data is not ready yet.
module fwd_match
    import pipe_pkg::*;
#(
    parameter int STAGES     = 3,
    parameter int LOAD_STAGE = STAGES - 1
) (
    input  logic [(STAGES-2)*SB_W-1:0] ent_i,
    input  logic [4:0]                 rs_i,
    input  logic                       used_i,
    output logic [$clog2(STAGES)-1:0]  sel_o,
    output logic                       ilk_o
);

    localparam int FW = $clog2(STAGES);

    sb_entry_t e;

    // Walk oldest to youngest so the youngest match is the one kept.
    always_comb begin
        e     = '0;
        sel_o = FW'(FWD_RF);
        ilk_o = 1'b0;
        for (int s = STAGES - 1; s >= 2; s--) begin
            e = ent_i[(s-2)*SB_W +: SB_W];
            if (src_hit(e, rs_i, used_i)) begin
                sel_o = FW'(s);
                ilk_o = e.is_load && (s < LOAD_STAGE);
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// In-order pipeline control: forwarding, load interlock, freeze, redirect.
// Define PIPE_CTRL_PERF_EN to add the perf_freeze/interlock/flush counters.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int STAGES     = 3,
    parameter int LOAD_STAGE = STAGES - 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      dec_valid,
    input  logic                      dec_reg_we,
    input  logic                      dec_is_load,
    input  logic [4:0]                dec_rd,
    input  logic [4:0]                ex_rs1,
    input  logic [4:0]                ex_rs2,
    input  logic                      ex_rs1_used,
    input  logic                      ex_rs2_used,
    input  logic                      redirect,
    input  logic                      ext_stall,
    input  logic                      mem_pause,
    output logic [STAGES-1:0]         stage_en,
    output logic [STAGES-1:0]         stage_valid,
    output logic [$clog2(STAGES)-1:0] fwd_a,
    output logic [$clog2(STAGES)-1:0] fwd_b,
    output logic                      ex_fire,
    output logic                      pc_en,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0]               perf_freeze,
    output logic [31:0]               perf_interlock,
    output logic [31:0]               perf_flush,
`endif
    output logic                      fetch_flush
);

    localparam int FW = $clog2(STAGES);

    sb_entry_t [STAGES-1:1] ent_q;
    sb_entry_t [STAGES-1:1] ent_d;
    logic                   kill0_q;
    logic                   kill0_d;

    sb_entry_t                   ent0;
    logic [(STAGES-2)*SB_W-1:0] tail_flat;
    logic [FW-1:0]               sel_a;
    logic [FW-1:0]               sel_b;
    logic                        ilk_a;
    logic                        ilk_b;
    logic                        freeze;
    logic                        ilk_raw;
    logic                        ilk_bub;

    // kill0_q marks the held stage 0 instruction as wrong-path.
    always_comb begin
        ent0.valid   = dec_valid & ~kill0_q;
        ent0.rd      = dec_rd;
        ent0.reg_we  = dec_reg_we;
        ent0.is_load = dec_is_load;
    end

    always_comb begin
        tail_flat = '0;
        for (int s = 2; s < STAGES; s++) begin
            tail_flat[(s-2)*SB_W +: SB_W] = ent_q[s];
        end
    end

    fwd_match #(
        .STAGES    (STAGES),
        .LOAD_STAGE(LOAD_STAGE)
    ) u_fwd_a (
        .ent_i (tail_flat),
        .rs_i  (ex_rs1),
        .used_i(ex_rs1_used),
        .sel_o (sel_a),
        .ilk_o (ilk_a)
    );

    fwd_match #(
        .STAGES    (STAGES),
        .LOAD_STAGE(LOAD_STAGE)
    ) u_fwd_b (
        .ent_i (tail_flat),
        .rs_i  (ex_rs2),
        .used_i(ex_rs2_used),
        .sel_o (sel_b),
        .ilk_o (ilk_b)
    );

    assign freeze  = ext_stall | mem_pause;
    assign ilk_raw = ilk_a | ilk_b;
    assign ilk_bub = ilk_raw & ~freeze & ~reset;

    always_comb begin
        stage_en    = '1;
        pc_en       = 1'b1;
        ex_fire     = 1'b0;
        fetch_flush = 1'b0;
        if (reset) begin
            fetch_flush = 1'b1;
        end else if (freeze) begin
            stage_en = '0;
            pc_en    = 1'b0;
        end else if (ilk_raw) begin
            stage_en[1:0] = 2'b00;
            pc_en         = 1'b0;
        end else begin
            ex_fire     = ent_q[1].valid;
            fetch_flush = ent_q[1].valid & redirect;
        end
    end

    always_comb begin
        stage_valid    = '0;
        stage_valid[0] = ent0.valid & ~reset;
        for (int s = 1; s < STAGES; s++) begin
            stage_valid[s] = ent_q[s].valid & ~reset;
        end
    end

    assign fwd_a = reset ? FW'(FWD_RF) : sel_a;
    assign fwd_b = reset ? FW'(FWD_RF) : sel_b;

    always_comb begin
        ent_d   = ent_q;
        kill0_d = kill0_q;
        if (stage_en[1]) begin
            ent_d[1] = fetch_flush ? '0 : ent0;
        end
        for (int s = 2; s < STAGES; s++) begin
            if (stage_en[s]) begin
                ent_d[s] = ent_q[s-1];
            end
        end
        // The stalled consumer stays in stage 1; stage 2 gets a hole.
        if (ilk_bub) begin
            ent_d[2] = '0;
        end
        if (stage_en[0]) begin
            kill0_d = fetch_flush;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ent_q   <= '0;
            kill0_q <= 1'b1;
        end else begin
            ent_q   <= ent_d;
            kill0_q <= kill0_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_freeze_q;
    logic [31:0] perf_ilk_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_freeze_q <= '0;
            perf_ilk_q    <= '0;
            perf_flush_q  <= '0;
        end else begin
            if (freeze) begin
                perf_freeze_q <= perf_freeze_q + 32'd1;
            end
            if (ilk_bub) begin
                perf_ilk_q <= perf_ilk_q + 32'd1;
            end
            if (fetch_flush) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign perf_freeze    = perf_freeze_q;
    assign perf_interlock = perf_ilk_q;
    assign perf_flush     = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a 4-stage and a 3-stage instance
// share stimulus; hand-derived expectations are queued per cycle.
module tb_pipe_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, dec_valid, dec_reg_we, dec_is_load;
    logic [4:0] dec_rd, ex_rs1, ex_rs2;
    logic       ex_rs1_used, ex_rs2_used;
    logic       redirect, ext_stall, mem_pause;

    logic [3:0] se4, sv4;
    logic [1:0] fa4, fb4;
    logic       ef4, pe4, ff4;
    logic [2:0] se3, sv3;
    logic [1:0] fa3, fb3;
    logic       ef3, pe3, ff3;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] pfz4, pil4, pfl4, pfz3, pil3, pfl3;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      nm;
        int         inst;
        logic [3:0] se;
        logic [3:0] sv;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       ef;
        logic       pe;
        logic       ff;
    } exp_t;

    exp_t sbq[$];

    pipe_ctrl #(.STAGES(4), .LOAD_STAGE(3)) dut4 (
        .clk(clk), .reset(reset),
        .dec_valid(dec_valid), .dec_reg_we(dec_reg_we),
        .dec_is_load(dec_is_load), .dec_rd(dec_rd),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rs1_used(ex_rs1_used), .ex_rs2_used(ex_rs2_used),
        .redirect(redirect), .ext_stall(ext_stall),
        .mem_pause(mem_pause),
        .stage_en(se4), .stage_valid(sv4),
        .fwd_a(fa4), .fwd_b(fb4),
        .ex_fire(ef4), .pc_en(pe4),
`ifdef PIPE_CTRL_PERF_EN
        .perf_freeze(pfz4), .perf_interlock(pil4),
        .perf_flush(pfl4),
`endif
        .fetch_flush(ff4)
    );

    pipe_ctrl #(.STAGES(3), .LOAD_STAGE(2)) dut3 (
        .clk(clk), .reset(reset),
        .dec_valid(dec_valid), .dec_reg_we(dec_reg_we),
        .dec_is_load(dec_is_load), .dec_rd(dec_rd),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rs1_used(ex_rs1_used), .ex_rs2_used(ex_rs2_used),
        .redirect(redirect), .ext_stall(ext_stall),
        .mem_pause(mem_pause),
        .stage_en(se3), .stage_valid(sv3),
        .fwd_a(fa3), .fwd_b(fb3),
        .ex_fire(ef3), .pc_en(pe3),
`ifdef PIPE_CTRL_PERF_EN
        .perf_freeze(pfz3), .perf_interlock(pil3),
        .perf_flush(pfl3),
`endif
        .fetch_flush(ff3)
    );

    function automatic void push_exp(
        string nm, int inst,
        logic [3:0] se, logic [3:0] sv,
        logic [1:0] fa, logic [1:0] fb,
        logic ef, logic pe, logic ff
    );
        exp_t e;
        e.nm = nm; e.inst = inst;
        e.se = se; e.sv = sv;
        e.fa = fa; e.fb = fb;
        e.ef = ef; e.pe = pe; e.ff = ff;
        sbq.push_back(e);
    endfunction

    // Compare every expectation queued for this cycle.
    always @(negedge clk) begin : mon
        exp_t       e;
        logic [14:0] act;
        logic [14:0] req;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.inst == 4)
                act = {se4, sv4, fa4, fb4, ef4, pe4, ff4};
            else
                act = {1'b0, se3, 1'b0, sv3, fa3, fb3, ef3, pe3, ff3};
            req = {e.se, e.sv, e.fa, e.fb, e.ef, e.pe, e.ff};
            checks++;
            if (act !== req) begin
                errors++;
                $display("FAIL %s/s%0d got se=%b sv=%b fa=%0d fb=%0d ef=%b pe=%b ff=%b want se=%b sv=%b fa=%0d fb=%0d ef=%b pe=%b ff=%b",
                    e.nm, e.inst,
                    act[14:11], act[10:7], act[6:5], act[4:3],
                    act[2], act[1], act[0],
                    e.se, e.sv, e.fa, e.fb, e.ef, e.pe, e.ff);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dec_valid = 0; dec_reg_we = 0; dec_is_load = 0;
        dec_rd = 0; ex_rs1 = 0; ex_rs2 = 0;
        ex_rs1_used = 0; ex_rs2_used = 0;
        redirect = 0; ext_stall = 0; mem_pause = 0;
    endtask

    task automatic drain();
        idle();
        reset = 0;
        repeat (4) step();
    endtask

    task automatic issue(input logic [4:0] rd, input logic ld);
        dec_valid = 1; dec_reg_we = 1;
        dec_rd = rd; dec_is_load = ld;
    endtask

    task automatic test_reset();
        reset = 1;
        issue(5'd3, 1'b0);
        ex_rs1 = 5'd3; ex_rs1_used = 1;
        push_exp("rst_hold", 4, 4'b1111, 4'b0000, 0, 0, 0, 1, 1);
        push_exp("rst_hold", 3, 4'b0111, 4'b0000, 0, 0, 0, 1, 1);
        step();
        reset = 0;
        push_exp("rst_rel", 4, 4'b1111, 4'b0000, 0, 0, 0, 1, 0);
        push_exp("rst_rel", 3, 4'b0111, 4'b0000, 0, 0, 0, 1, 0);
        step();
        push_exp("rst_post", 4, 4'b1111, 4'b0001, 0, 0, 0, 1, 0);
        push_exp("rst_post", 3, 4'b0111, 4'b0001, 0, 0, 0, 1, 0);
        step();
    endtask

    task automatic test_fwd_alu();
        drain();
        issue(5'd5, 1'b0); step();
        issue(5'd9, 1'b0); step();
        dec_valid = 0;
        ex_rs1 = 5'd5; ex_rs1_used = 1;
        ex_rs2 = 5'd5; ex_rs2_used = 0;
        push_exp("alu_fwd", 3, 4'b0111, 4'b0110, 2, 0, 1, 1, 0);
        push_exp("alu_fwd", 4, 4'b1111, 4'b0110, 2, 0, 1, 1, 0);
        step();
        ex_rs2 = 5'd9; ex_rs2_used = 1;
        push_exp("alu_deep", 4, 4'b1111, 4'b1100, 3, 2, 0, 1, 0);
        push_exp("alu_deep", 3, 4'b0111, 4'b0100, 0, 2, 0, 1, 0);
        step();
    endtask

    task automatic test_priority();
        drain();
        issue(5'd6, 1'b0); step();
        issue(5'd6, 1'b0); step();
        dec_valid = 0; step();
        ex_rs1 = 5'd6; ex_rs1_used = 1;
        ex_rs2 = 5'd6; ex_rs2_used = 1;
        push_exp("youngest", 4, 4'b1111, 4'b1100, 2, 2, 0, 1, 0);
        push_exp("youngest", 3, 4'b0111, 4'b0100, 2, 2, 0, 1, 0);
        step();
    endtask

    task automatic test_x0();
        drain();
        issue(5'd0, 1'b1); step();
        dec_valid = 0; step();
        ex_rs1 = 5'd0; ex_rs1_used = 1;
        ex_rs2 = 5'd0; ex_rs2_used = 1;
        push_exp("x0_nofwd", 4, 4'b1111, 4'b0100, 0, 0, 0, 1, 0);
        push_exp("x0_nofwd", 3, 4'b0111, 4'b0100, 0, 0, 0, 1, 0);
        step();
    endtask

    task automatic test_load_interlock();
        drain();
        issue(5'd7, 1'b1); step();
        issue(5'd8, 1'b0); step();
        issue(5'd10, 1'b0);
        ex_rs2 = 5'd7; ex_rs2_used = 1;
        push_exp("ld_ilk", 4, 4'b1100, 4'b0111, 0, 2, 0, 0, 0);
        push_exp("ld_ok", 3, 4'b0111, 4'b0111, 0, 2, 1, 1, 0);
        step();
        push_exp("ld_fwd", 4, 4'b1111, 4'b1011, 0, 3, 1, 1, 0);
        push_exp("ld_post", 3, 4'b0111, 4'b0111, 0, 0, 1, 1, 0);
        step();
    endtask

    task automatic test_redirect();
`ifdef PIPE_CTRL_PERF_EN
        logic [31:0] b_fl;
`endif
        drain();
`ifdef PIPE_CTRL_PERF_EN
        b_fl = pfl4;
`endif
        issue(5'd11, 1'b0); step();
        issue(5'd12, 1'b0);
        redirect = 1;
        push_exp("redir", 4, 4'b1111, 4'b0011, 0, 0, 1, 1, 1);
        push_exp("redir", 3, 4'b0111, 4'b0011, 0, 0, 1, 1, 1);
        step();
        issue(5'd13, 1'b0);
        push_exp("redir_ign", 4, 4'b1111, 4'b0100, 0, 0, 0, 1, 0);
        push_exp("redir_ign", 3, 4'b0111, 4'b0100, 0, 0, 0, 1, 0);
        step();
        redirect = 0;
        push_exp("s0_kill", 4, 4'b1111, 4'b1001, 0, 0, 0, 1, 0);
        push_exp("s0_kill", 3, 4'b0111, 4'b0001, 0, 0, 0, 1, 0);
        step();
`ifdef PIPE_CTRL_PERF_EN
        checks++;
        if (pfl4 - b_fl !== 32'd1) begin
            errors++;
            $display("FAIL perf_flush delta got=%0d want=1", pfl4 - b_fl);
        end
`endif
    endtask

    task automatic test_freeze();
`ifdef PIPE_CTRL_PERF_EN
        logic [31:0] b_fz, b_il;
`endif
        drain();
`ifdef PIPE_CTRL_PERF_EN
        b_fz = pfz4; b_il = pil4;
`endif
        issue(5'd7, 1'b1); step();
        issue(5'd8, 1'b0); step();
        issue(5'd10, 1'b0);
        ex_rs2 = 5'd7; ex_rs2_used = 1;
        redirect = 1;
        for (int i = 0; i < 5; i++) begin
            ext_stall = (i < 3);
            mem_pause = (i >= 2);
            push_exp("frz", 4, 4'b0000, 4'b0111, 0, 2, 0, 0, 0);
            push_exp("frz", 3, 4'b0000, 4'b0111, 0, 2, 0, 0, 0);
            step();
        end
        ext_stall = 0; mem_pause = 0;
        push_exp("frz_ilk", 4, 4'b1100, 4'b0111, 0, 2, 0, 0, 0);
        push_exp("frz_rel", 3, 4'b0111, 4'b0111, 0, 2, 1, 1, 1);
        step();
        push_exp("frz_fwd", 4, 4'b1111, 4'b1011, 0, 3, 1, 1, 1);
        push_exp("frz_post", 3, 4'b0111, 4'b0100, 0, 0, 0, 1, 0);
        step();
        push_exp("frz_once", 4, 4'b1111, 4'b0100, 0, 0, 0, 1, 0);
        push_exp("frz_tail", 3, 4'b0111, 4'b0001, 0, 0, 0, 1, 0);
        step();
`ifdef PIPE_CTRL_PERF_EN
        checks++;
        if (pfz4 - b_fz !== 32'd5) begin
            errors++;
            $display("FAIL perf_freeze delta got=%0d want=5", pfz4 - b_fz);
        end
        checks++;
        if (pil4 - b_il !== 32'd1) begin
            errors++;
            $display("FAIL perf_interlock delta got=%0d want=1", pil4 - b_il);
        end
`endif
    endtask

    task automatic test_reset_mid();
        drain();
        issue(5'd1, 1'b0); step();
        issue(5'd2, 1'b0); step();
        issue(5'd3, 1'b0);
        ext_stall = 1;
        ex_rs1 = 5'd1; ex_rs1_used = 1;
        push_exp("pre_rst", 3, 4'b0000, 4'b0111, 2, 0, 0, 0, 0);
        push_exp("pre_rst", 4, 4'b0000, 4'b0111, 2, 0, 0, 0, 0);
        step();
        reset = 1;
        push_exp("rst_mid", 4, 4'b1111, 4'b0000, 0, 0, 0, 1, 1);
        push_exp("rst_mid", 3, 4'b0111, 4'b0000, 0, 0, 0, 1, 1);
        step();
        reset = 0; ext_stall = 0;
        ex_rs2 = 5'd2; ex_rs2_used = 1;
        push_exp("post_rst", 4, 4'b1111, 4'b0000, 0, 0, 0, 1, 0);
        push_exp("post_rst", 3, 4'b0111, 4'b0000, 0, 0, 0, 1, 0);
        step();
`ifdef PIPE_CTRL_PERF_EN
        checks++;
        if (pfz4 !== 32'd0) begin
            errors++;
            $display("FAIL perf_freeze after reset got=%0d want=0", pfz4);
        end
`endif
    endtask

    initial begin
        idle();
        reset = 1;
        step();
        step();
        test_reset();
        test_fwd_alu();
        test_priority();
        test_x0();
        test_load_interlock();
        test_redirect();
        test_freeze();
        test_reset_mid();
        @(negedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d want=0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
